// File: rtl/aes_round_seq.sv
// Control sequencer for the AES datapath: decodes an opcode and steps aes_enc, S_box and key_gen
// through single rounds, full NR-round encryption, or a key-generation assist.
package aes_pkg;
   typedef enum logic [2:0] {
      NOOP            = 3'd0,
      AESENC          = 3'd1,
      AESENCLAST      = 3'd2,
      AESENCFULL      = 3'd3,
      AESKEYGENASSIST = 3'd4
   } opcode;
endpackage

module aes_round_seq #(
   parameter int NR       = 10,
   parameter int SBOX_LAT = 1,
   parameter int CNT_W    = $clog2(NR + 1)
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             start_i,
   input  aes_pkg::opcode   opcode_i,
   input  logic             abort_i,
   output logic             ready_o,
   output logic             full_enc_o,
   output logic             final_rnd_o,
   output logic             zero_rnd_o,
   output logic             key_sel_o,
   output logic             key_sub_o,
   output logic             gen_key_o,
   output logic             r_con_ctrl_o,
   output logic             next_rnd_o,
   output logic [CNT_W-1:0] rnd_cnt_o,
   output logic             cipher_ready_o,
   output logic             key_ready_o,
   output logic             err_o
);

   localparam int SB_W = (SBOX_LAT > 1) ? $clog2(SBOX_LAT) : 1;

   if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
      $error("aes_round_seq: NR must be 10, 12 or 14");
   end
   if (SBOX_LAT < 1) begin : g_bad_sbox_lat
      $error("aes_round_seq: SBOX_LAT must be at least 1");
   end

   typedef enum logic [2:0] {IDLE, ZERO, SBOX, ROUND, KEYGEN, DONE} state_t;

   state_t             state_q, state_d;
   aes_pkg::opcode     op_q, op_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [SB_W-1:0]    sb_q, sb_d;
   logic               err_q, err_d;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q <= IDLE;
         op_q    <= aes_pkg::NOOP;
         cnt_q   <= '0;
         sb_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         sb_q    <= sb_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      sb_d    = sb_q;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               op_d = opcode_i;
               case (opcode_i)
                  aes_pkg::NOOP: ;
                  aes_pkg::AESENC, aes_pkg::AESENCLAST, aes_pkg::AESKEYGENASSIST: state_d = SBOX;
                  aes_pkg::AESENCFULL: state_d = ZERO;
                  default: err_d = 1'b1;
               endcase
            end
         end
         ZERO: state_d = SBOX;
         SBOX: begin
            // Dwell SBOX_LAT cycles so the S_box result is settled before the round uses it.
            if (sb_q == SB_W'(SBOX_LAT - 1)) begin
               sb_d    = '0;
               state_d = (op_q == aes_pkg::AESKEYGENASSIST) ? KEYGEN : ROUND;
            end else begin
               sb_d = sb_q + 1'b1;
            end
         end
         ROUND: begin
            cnt_d = cnt_q + 1'b1;
            if (op_q == aes_pkg::AESENCFULL && cnt_q != CNT_W'(NR - 1)) state_d = SBOX;
            else state_d = DONE;
         end
         KEYGEN: state_d = DONE;
         DONE: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
         default: state_d = IDLE;
      endcase
      if (abort_i && state_q != IDLE) begin
         state_d = IDLE;
         cnt_d   = '0;
         sb_d    = '0;
      end
   end

   // cnt_q counts completed rounds, so the round in progress is cnt_q + 1.
   always_comb begin
      ready_o        = (state_q == IDLE);
      full_enc_o     = 1'b0;
      final_rnd_o    = 1'b0;
      zero_rnd_o     = 1'b0;
      key_sel_o      = 1'b0;
      key_sub_o      = 1'b0;
      gen_key_o      = 1'b0;
      r_con_ctrl_o   = 1'b0;
      next_rnd_o     = 1'b0;
      rnd_cnt_o      = '0;
      cipher_ready_o = 1'b0;
      key_ready_o    = 1'b0;
      err_o          = err_q;
      case (state_q)
         ZERO: begin
            zero_rnd_o   = 1'b1;
            r_con_ctrl_o = 1'b1;
         end
         SBOX: key_sub_o = (op_q == aes_pkg::AESKEYGENASSIST);
         ROUND: begin
            rnd_cnt_o = cnt_q + 1'b1;
            if (op_q == aes_pkg::AESENCFULL) begin
               gen_key_o  = 1'b1;
               next_rnd_o = 1'b1;
               key_sel_o  = 1'b1;
               if (cnt_q == CNT_W'(NR - 1)) final_rnd_o = 1'b1;
               else full_enc_o = 1'b1;
            end else if (op_q == aes_pkg::AESENCLAST) begin
               final_rnd_o = 1'b1;
            end else begin
               full_enc_o = 1'b1;
            end
         end
         KEYGEN: gen_key_o = 1'b1;
         DONE: begin
            key_ready_o    = (op_q == aes_pkg::AESKEYGENASSIST);
            cipher_ready_o = (op_q != aes_pkg::AESKEYGENASSIST);
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_aes_round_seq.sv
// Directed bench for aes_round_seq: default instance (NR=10, SBOX_LAT=1) plus an
// NR=12, SBOX_LAT=2 instance for the parametrised latency.
module tb_aes_round_seq;

   // Output vector bit order: ready full fin zero ksel ksub gen rcon nxt cready kready err
   localparam logic [11:0] V_IDLE     = 12'b1000_0000_0000;
   localparam logic [11:0] V_BUSY     = 12'b0000_0000_0000;
   localparam logic [11:0] V_ENC_RND  = 12'b0100_0000_0000;
   localparam logic [11:0] V_LAST_RND = 12'b0010_0000_0000;
   localparam logic [11:0] V_ZERO     = 12'b0001_0001_0000;
   localparam logic [11:0] V_FULL_RND = 12'b0100_1010_1000;
   localparam logic [11:0] V_FULL_FIN = 12'b0010_1010_1000;
   localparam logic [11:0] V_KSUB     = 12'b0000_0100_0000;
   localparam logic [11:0] V_KGEN     = 12'b0000_0010_0000;
   localparam logic [11:0] V_CDONE    = 12'b0000_0000_0100;
   localparam logic [11:0] V_KDONE    = 12'b0000_0000_0010;
   localparam logic [11:0] V_ERR      = 12'b1000_0000_0001;

   logic clk, nrst;
   logic start_i, abort_i;
   aes_pkg::opcode opcode_i;
   logic ready, full, fin, zero, ksel, ksub, gen, rcon, nxt, cready, kready, err;
   logic [3:0] rnd;
   logic start2, abort2;
   aes_pkg::opcode op2;
   logic ready2, full2, fin2, zero2, ksel2, ksub2, gen2, rcon2, nxt2, cready2, kready2, err2;
   logic [3:0] rnd2;
   logic [11:0] outs, outs2;

   int checks = 0;
   int errors = 0;

   assign outs  = {ready, full, fin, zero, ksel, ksub, gen, rcon, nxt, cready, kready, err};
   assign outs2 = {ready2, full2, fin2, zero2, ksel2, ksub2, gen2, rcon2, nxt2, cready2, kready2, err2};

   aes_round_seq dut (
      .clk(clk), .nrst(nrst), .start_i(start_i), .opcode_i(opcode_i), .abort_i(abort_i),
      .ready_o(ready), .full_enc_o(full), .final_rnd_o(fin), .zero_rnd_o(zero),
      .key_sel_o(ksel), .key_sub_o(ksub), .gen_key_o(gen), .r_con_ctrl_o(rcon),
      .next_rnd_o(nxt), .rnd_cnt_o(rnd), .cipher_ready_o(cready), .key_ready_o(kready),
      .err_o(err)
   );

   aes_round_seq #(.NR(12), .SBOX_LAT(2)) dut2 (
      .clk(clk), .nrst(nrst), .start_i(start2), .opcode_i(op2), .abort_i(abort2),
      .ready_o(ready2), .full_enc_o(full2), .final_rnd_o(fin2), .zero_rnd_o(zero2),
      .key_sel_o(ksel2), .key_sub_o(ksub2), .gen_key_o(gen2), .r_con_ctrl_o(rcon2),
      .next_rnd_o(nxt2), .rnd_cnt_o(rnd2), .cipher_ready_o(cready2), .key_ready_o(kready2),
      .err_o(err2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a start for one edge; returns at cycle 1 of the operation.
   task automatic issue(input aes_pkg::opcode op);
      start_i  = 1'b1;
      opcode_i = op;
      tick();
      start_i  = 1'b0;
      opcode_i = aes_pkg::NOOP;
   endtask

   task automatic test_reset();
      nrst = 1'b1;
      #2 nrst = 1'b0;
      #1;
      checks++;
      if (outs !== V_IDLE || rnd !== 4'd0) begin
         errors++;
         $display("FAIL reset_outs got %b/%0d want %b/0", outs, rnd, V_IDLE);
      end
      checks++;
      if (outs2 !== V_IDLE || rnd2 !== 4'd0) begin
         errors++;
         $display("FAIL reset_outs2 got %b/%0d want %b/0", outs2, rnd2, V_IDLE);
      end
      tick();
      tick();
      nrst = 1'b1;
      tick();
      checks++;
      if (outs !== V_IDLE) begin
         errors++;
         $display("FAIL reset_release got %b want %b", outs, V_IDLE);
      end
   endtask

   task automatic test_enc(input aes_pkg::opcode op, input logic [11:0] rnd_v, input string nm);
      logic [11:0] exp_v [1:4];
      exp_v[1] = V_BUSY; exp_v[2] = rnd_v; exp_v[3] = V_CDONE; exp_v[4] = V_IDLE;
      issue(op);
      for (int c = 1; c <= 4; c++) begin
         checks++;
         if (outs !== exp_v[c] || rnd !== ((c == 2) ? 4'd1 : 4'd0)) begin
            errors++;
            $display("FAIL %s_c%0d got %b/%0d want %b/%0d", nm, c, outs, rnd, exp_v[c], (c == 2) ? 1 : 0);
         end
         if (c < 4) tick();
      end
   endtask

   task automatic test_keygen();
      logic [11:0] exp_v [1:4];
      exp_v[1] = V_KSUB; exp_v[2] = V_KGEN; exp_v[3] = V_KDONE; exp_v[4] = V_IDLE;
      issue(aes_pkg::AESKEYGENASSIST);
      for (int c = 1; c <= 4; c++) begin
         checks++;
         if (outs !== exp_v[c] || rnd !== 4'd0) begin
            errors++;
            $display("FAIL keygen_c%0d got %b/%0d want %b/0", c, outs, rnd, exp_v[c]);
         end
         if (c < 4) tick();
      end
   endtask

   // Full encryption with AESENC start held high throughout the busy period.
   task automatic test_encfull_busy_start();
      logic [11:0] ev;
      logic [3:0]  er;
      int pulses = 0;
      issue(aes_pkg::AESENCFULL);
      start_i  = 1'b1;
      opcode_i = aes_pkg::AESENC;
      for (int c = 1; c <= 22; c++) begin
         ev = V_BUSY;
         er = 4'd0;
         if (c == 1) ev = V_ZERO;
         else if (c == 22) ev = V_CDONE;
         else if (c % 2 == 1) begin
            er = 4'((c - 1) / 2);
            ev = (er == 4'd10) ? V_FULL_FIN : V_FULL_RND;
         end
         if (cready === 1'b1) pulses++;
         checks++;
         if (outs !== ev || rnd !== er) begin
            errors++;
            $display("FAIL encfull_c%0d got %b/%0d want %b/%0d", c, outs, rnd, ev, er);
         end
         if (c < 22) tick();
      end
      start_i  = 1'b0;
      opcode_i = aes_pkg::NOOP;
      tick();
      checks++;
      if (outs !== V_IDLE) begin
         errors++;
         $display("FAIL encfull_idle got %b want %b", outs, V_IDLE);
      end
      checks++;
      if (pulses != 1) begin
         errors++;
         $display("FAIL encfull_pulses got %0d want 1", pulses);
      end
   endtask

   task automatic test_back_to_back();
      issue(aes_pkg::AESENC);
      tick(); tick(); tick();
      issue(aes_pkg::AESENCLAST);
      checks++;
      if (outs !== V_BUSY) begin
         errors++;
         $display("FAIL b2b_second_accept got %b want %b", outs, V_BUSY);
      end
      tick();
      checks++;
      if (outs !== V_LAST_RND) begin
         errors++;
         $display("FAIL b2b_second_round got %b want %b", outs, V_LAST_RND);
      end
      tick(); tick();
   endtask

   task automatic test_abort();
      issue(aes_pkg::AESENCFULL);
      for (int c = 1; c < 7; c++) tick();
      checks++;
      if (outs !== V_FULL_RND || rnd !== 4'd3) begin
         errors++;
         $display("FAIL abort_pre got %b/%0d want %b/3", outs, rnd, V_FULL_RND);
      end
      abort_i = 1'b1;
      tick();
      abort_i = 1'b0;
      checks++;
      if (outs !== V_IDLE || rnd !== 4'd0) begin
         errors++;
         $display("FAIL abort_idle got %b/%0d want %b/0", outs, rnd, V_IDLE);
      end
      issue(aes_pkg::AESENC);
      tick();
      checks++;
      if (outs !== V_ENC_RND || rnd !== 4'd1) begin
         errors++;
         $display("FAIL abort_restart got %b/%0d want %b/1", outs, rnd, V_ENC_RND);
      end
      tick();
      checks++;
      if (outs !== V_CDONE) begin
         errors++;
         $display("FAIL abort_restart_done got %b want %b", outs, V_CDONE);
      end
      tick();
   endtask

   task automatic test_noop_illegal();
      issue(aes_pkg::NOOP);
      checks++;
      if (outs !== V_IDLE) begin
         errors++;
         $display("FAIL noop got %b want %b", outs, V_IDLE);
      end
      issue(aes_pkg::opcode'(3'd6));
      checks++;
      if (outs !== V_ERR) begin
         errors++;
         $display("FAIL illegal_err got %b want %b", outs, V_ERR);
      end
      tick();
      checks++;
      if (outs !== V_IDLE) begin
         errors++;
         $display("FAIL illegal_clear got %b want %b", outs, V_IDLE);
      end
      abort_i = 1'b1;
      issue(aes_pkg::AESKEYGENASSIST);
      abort_i = 1'b0;
      checks++;
      if (outs !== V_KSUB) begin
         errors++;
         $display("FAIL abort_in_idle got %b want %b", outs, V_KSUB);
      end
      tick(); tick(); tick();
   endtask

   task automatic test_reset_mid();
      issue(aes_pkg::AESENCFULL);
      tick(); tick(); tick(); tick();
      nrst = 1'b0;
      #1;
      checks++;
      if (outs !== V_IDLE || rnd !== 4'd0) begin
         errors++;
         $display("FAIL reset_mid got %b/%0d want %b/0", outs, rnd, V_IDLE);
      end
      tick();
      nrst = 1'b1;
      tick();
      checks++;
      if (outs !== V_IDLE) begin
         errors++;
         $display("FAIL reset_mid_after got %b want %b", outs, V_IDLE);
      end
   endtask

   // NR=12, SBOX_LAT=2: ZERO at 1, round r at 1+3r, DONE at 12*3+2 = 38.
   task automatic test_params();
      logic [11:0] ev;
      logic [3:0]  er;
      start2 = 1'b1;
      op2    = aes_pkg::AESENCFULL;
      tick();
      start2 = 1'b0;
      op2    = aes_pkg::NOOP;
      for (int c = 1; c <= 39; c++) begin
         ev = V_BUSY;
         er = 4'd0;
         if (c == 1) ev = V_ZERO;
         else if (c == 38) ev = V_CDONE;
         else if (c == 39) ev = V_IDLE;
         else if ((c - 1) % 3 == 0) begin
            er = 4'((c - 1) / 3);
            ev = (er == 4'd12) ? V_FULL_FIN : V_FULL_RND;
         end
         checks++;
         if (outs2 !== ev || rnd2 !== er) begin
            errors++;
            $display("FAIL param_c%0d got %b/%0d want %b/%0d", c, outs2, rnd2, ev, er);
         end
         if (c < 39) tick();
      end
   endtask

   initial begin
      start_i = 1'b0; abort_i = 1'b0; opcode_i = aes_pkg::NOOP;
      start2  = 1'b0; abort2  = 1'b0; op2      = aes_pkg::NOOP;
      test_reset();
      test_enc(aes_pkg::AESENC, V_ENC_RND, "enc");
      test_enc(aes_pkg::AESENCLAST, V_LAST_RND, "enclast");
      test_keygen();
      test_encfull_busy_start();
      test_back_to_back();
      test_abort();
      test_noop_illegal();
      test_reset_mid();
      test_params();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
